// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the 4 x 12-bit register file
// and the blocks that drive its write port.
package regfile_pkg;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 2;
    localparam int NREGS  = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// with ptr moving just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic          found;

    // Scan ptr, ptr+1, ... wrapping at NREQ; the first asserted request wins.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = '0;
        sum      = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_next = (idx == PW'(NREQ-1)) ? '0 : idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NREQ requesters (round-robin),
// registering the winning write. Optional REGWR_CONTENTION_CNT_EN adds a contention counter.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_rd,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      rd,
    output logic [DATA_W-1:0]      WriteData
`ifdef REGWR_CONTENTION_CNT_EN
    ,
    input  logic                   contention_clr,
    output logic [7:0]             contention_cnt
`endif
);

    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   gnt;
    logic              grant;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // A stalled pipeline sees no requests, so nothing is granted and ptr holds.
    assign arb_req = stall ? '0 : req_valid;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (arb_req),
        .advance (~stall),
        .gnt     (gnt)
    );

    assign req_ready = reset_n ? gnt : '0;
    assign grant     = |req_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Address and data hold between writes; only the enable drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite  <= 1'b0;
            rd        <= '0;
            WriteData <= '0;
        end else if (grant) begin
            RegWrite  <= 1'b1;
            rd        <= sel_rd;
            WriteData <= sel_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

`ifdef REGWR_CONTENTION_CNT_EN
    logic multi_valid;

    assign multi_valid = |(req_valid & (req_valid - NREQ'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contention_cnt <= '0;
        end else if (contention_clr) begin
            contention_cnt <= '0;
        end else if (!stall && multi_valid && (contention_cnt != 8'hFF)) begin
            contention_cnt <= contention_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register-file model
// fed from the write port. Contention checks run when REGWR_CONTENTION_CNT_EN is defined.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [2:0]  req_valid;
    logic [5:0]  req_rd;
    logic [35:0] req_data;
    logic [2:0]  req_ready;
    logic        RegWrite;
    logic [1:0]  rd;
    logic [11:0] WriteData;
`ifdef REGWR_CONTENTION_CNT_EN
    logic        contention_clr;
    logic [7:0]  contention_cnt;
`endif

    logic [11:0] regs [4] = '{default: '0};

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    regfile_write_arbiter #(
        .NREQ   (3),
        .DATA_W (12),
        .ADDR_W (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .RegWrite  (RegWrite),
        .rd        (rd),
        .WriteData (WriteData)
`ifdef REGWR_CONTENTION_CNT_EN
        ,
        .contention_clr (contention_clr),
        .contention_cnt (contention_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: writes at the edge that ends the RegWrite cycle.
    always @(posedge clk) begin
        if (RegWrite) regs[rd] <= WriteData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic stallVal);
        req_valid = valid;
        stall     = stallVal;
    endtask

    task automatic setRequester(input int i, input logic [1:0] r, input logic [11:0] d);
        req_rd[i*2 +: 2]    = r;
        req_data[i*12 +: 12] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        req_rd   = '0;
        req_data = '0;
        applyStimulus(3'b000, 1'b0);
`ifdef REGWR_CONTENTION_CNT_EN
        contention_clr = 1'b0;
`endif
        tick();
        tick();

        // Reset state with every requester asking.
        setRequester(0, 2'd0, 12'h100);
        setRequester(1, 2'd1, 12'h101);
        setRequester(2, 2'd2, 12'h102);
        applyStimulus(3'b111, 1'b0);
        #1;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_regwrite", 32'(RegWrite), 32'h0);
        checkOutput("reset_rd", 32'(rd), 32'h0);
        checkOutput("reset_wdata", 32'(WriteData), 32'h0);

        reset_n = 1'b1;
        #1;
        checkOutput("release_ready", 32'(req_ready), 32'h1);
        tick();
        checkOutput("pre_reset_regwrite", 32'(RegWrite), 32'h1);
        checkOutput("pre_reset_wdata", 32'(WriteData), 32'h100);
        checkOutput("ptr_moved_ready", 32'(req_ready), 32'h2);

        // Asynchronous reset mid-cycle discards the pending write.
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_regwrite", 32'(RegWrite), 32'h0);
        checkOutput("async_rd", 32'(rd), 32'h0);
        checkOutput("async_wdata", 32'(WriteData), 32'h0);
        checkOutput("async_ready", 32'(req_ready), 32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("rerelease_ready", 32'(req_ready), 32'h1);
        applyStimulus(3'b000, 1'b0);
        tick();
        checkOutput("idle_regwrite", 32'(RegWrite), 32'h0);
        checkOutput("reset_no_write", 32'(regs[0]), 32'h0);

        // Single write from requester 1.
        setRequester(1, 2'd3, 12'hABC);
        applyStimulus(3'b010, 1'b0);
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("single_regwrite", 32'(RegWrite), 32'h1);
        checkOutput("single_rd", 32'(rd), 32'h3);
        checkOutput("single_wdata", 32'(WriteData), 32'hABC);
        tick();
        checkOutput("single_readback", 32'(regs[3]), 32'hABC);
        checkOutput("single_regwrite_drop", 32'(RegWrite), 32'h0);

        // Grant requester 2 alone so the pointer wraps back to 0.
        setRequester(2, 2'd0, 12'h0EE);
        applyStimulus(3'b100, 1'b0);
        #1;
        checkOutput("wrap_ready", 32'(req_ready), 32'h4);
        tick();

        // Round-robin with all three requesters continuously valid.
        setRequester(0, 2'd0, 12'h300);
        setRequester(1, 2'd1, 12'h311);
        setRequester(2, 2'd2, 12'h322);
        applyStimulus(3'b111, 1'b0);
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
            tick();
            checkOutput($sformatf("rr_regwrite_%0d", k), 32'(RegWrite), 32'h1);
            checkOutput($sformatf("rr_rd_%0d", k), 32'(rd), 32'(k % 3));
            checkOutput($sformatf("rr_wdata_%0d", k), 32'(WriteData), 32'h300 + 32'(k % 3) * 32'h11);
        end
        applyStimulus(3'b000, 1'b0);
        tick();
        checkOutput("rr_r0", 32'(regs[0]), 32'h300);
        checkOutput("rr_r1", 32'(regs[1]), 32'h311);
        checkOutput("rr_r2", 32'(regs[2]), 32'h322);

        // Same-rd collision: requester 0 then requester 2 both write r1.
        setRequester(0, 2'd1, 12'h111);
        setRequester(2, 2'd1, 12'h222);
        applyStimulus(3'b101, 1'b0);
        #1;
        checkOutput("coll_ready0", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(3'b100, 1'b0);
        checkOutput("coll_wdata0", 32'(WriteData), 32'h111);
        #1;
        checkOutput("coll_ready2", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("coll_r1_first", 32'(regs[1]), 32'h111);
        checkOutput("coll_wdata2", 32'(WriteData), 32'h222);
        tick();
        checkOutput("coll_r1_last", 32'(regs[1]), 32'h222);

        // A grant just before stall still writes; no grants during the stall.
        setRequester(0, 2'd2, 12'h555);
        applyStimulus(3'b001, 1'b0);
        #1;
        checkOutput("prestall_ready", 32'(req_ready), 32'h1);
        tick();
        setRequester(0, 2'd3, 12'h666);
        applyStimulus(3'b001, 1'b1);
        #1;
        checkOutput("stall1_ready", 32'(req_ready), 32'h0);
        checkOutput("stall1_regwrite", 32'(RegWrite), 32'h1);
        checkOutput("stall1_wdata", 32'(WriteData), 32'h555);
        tick();
        checkOutput("stall2_ready", 32'(req_ready), 32'h0);
        checkOutput("stall2_regwrite", 32'(RegWrite), 32'h0);
        checkOutput("stall2_rd_hold", 32'(rd), 32'h2);
        checkOutput("stall_r2", 32'(regs[2]), 32'h555);
        tick();
        checkOutput("stall3_ready", 32'(req_ready), 32'h0);
        checkOutput("stall3_regwrite", 32'(RegWrite), 32'h0);
        tick();
        applyStimulus(3'b001, 1'b0);
        #1;
        checkOutput("poststall_ready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("poststall_regwrite", 32'(RegWrite), 32'h1);
        checkOutput("poststall_rd", 32'(rd), 32'h3);
        checkOutput("poststall_wdata", 32'(WriteData), 32'h666);
        tick();
        checkOutput("poststall_r3", 32'(regs[3]), 32'h666);

`ifdef REGWR_CONTENTION_CNT_EN
        // Contention counter: clear, count, saturate, clear again.
        contention_clr = 1'b1;
        tick();
        contention_clr = 1'b0;
        checkOutput("cnt_cleared", 32'(contention_cnt), 32'h0);
        applyStimulus(3'b011, 1'b0);
        repeat (10) tick();
        checkOutput("cnt_ten", 32'(contention_cnt), 32'd10);
        applyStimulus(3'b011, 1'b1);
        repeat (3) tick();
        checkOutput("cnt_stall_hold", 32'(contention_cnt), 32'd10);
        applyStimulus(3'b011, 1'b0);
        repeat (290) tick();
        checkOutput("cnt_saturated", 32'(contention_cnt), 32'd255);
        contention_clr = 1'b1;
        tick();
        contention_clr = 1'b0;
        applyStimulus(3'b000, 1'b0);
        checkOutput("cnt_clr", 32'(contention_cnt), 32'h0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
